// File: rtl/ved_mac_64.sv
// Pipelined multiply-accumulate stage: a registered 64x64 Vedic product feeds a
// frame accumulator whose result sits in a held output register with backpressure.
module ved_mac_64 #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_a,
  input  logic [63:0]        in_b,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_acc,
  output logic [CNT_W-1:0]   out_cnt,
  output logic               out_ovf
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [127:0]       p_reg;
  logic               p_last;
  logic               p_valid;
  logic [127:0]       acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic [127:0]       acc_base;
  logic [CNT_W-1:0]   cnt_base;
  logic               ovf_base;
  logic [CNT_W-1:0]   cnt_next;
  logic [128:0]       sum;
  logic               stall;
  logic               consume;
  logic               accept;

  // Urdhva-style split into four 32x32 partial products, crosswise terms summed
  function automatic logic [127:0] ved_64x64(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ll, lh, hl, hh;
    logic [64:0] mid;
    ll  = {32'b0, a[31:0]}  * {32'b0, b[31:0]};
    lh  = {32'b0, a[31:0]}  * {32'b0, b[63:32]};
    hl  = {32'b0, a[63:32]} * {32'b0, b[31:0]};
    hh  = {32'b0, a[63:32]} * {32'b0, b[63:32]};
    mid = {1'b0, lh} + {1'b0, hl};
    return {hh, ll} + {31'b0, mid, 32'b0};
  endfunction

  // Only a last beat can be blocked, and only by an unconsumed held result
  always_comb begin
    stall    = p_last && out_valid && !out_ready;
    consume  = p_valid && !stall;
    in_ready = !rst && (!p_valid || !stall);
    accept   = in_valid && in_ready;
    acc_base = (state == RUN) ? acc : '0;
    cnt_base = (state == RUN) ? cnt : '0;
    ovf_base = (state == RUN) ? ovf : 1'b0;
    sum      = {1'b0, acc_base} + {1'b0, p_reg};
    cnt_next = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg   <= '0;
      p_last  <= 1'b0;
      p_valid <= 1'b0;
    end else if (accept) begin
      p_reg   <= ved_64x64(in_a, in_b);
      p_last  <= in_last;
      p_valid <= 1'b1;
    end else if (consume) begin
      p_valid <= 1'b0;
    end
  end

  // A last beat may load the output in the same cycle the old result is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (consume) begin
      if (p_last) begin
        out_acc   <= sum[127:0];
        out_ovf   <= ovf_base | sum[128];
        out_cnt   <= cnt_next;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
        state     <= IDLE;
      end else begin
        acc       <= sum[127:0];
        ovf       <= ovf_base | sum[128];
        cnt       <= cnt_next;
        state     <= RUN;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ved_mac_64.sv
// Self-checking bench for ved_mac_64: directed scenarios plus a randomized run
// scored against a frame-level arithmetic model.
module tb_ved_mac_64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_a = '0;
  logic [63:0]  in_b = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_acc;
  logic [15:0]  out_cnt;
  logic         out_ovf;

  logic         s_in_valid = 1'b0;
  logic         s_in_ready;
  logic [63:0]  s_in_a = '0;
  logic [63:0]  s_in_b = '0;
  logic         s_in_last = 1'b0;
  logic         s_out_valid;
  logic         s_out_ready = 1'b1;
  logic [127:0] s_out_acc;
  logic [1:0]   s_out_cnt;
  logic         s_out_ovf;

  int tests_run = 0;
  int fails = 0;

  typedef struct {
    logic [127:0] acc;
    int           cnt;
    bit           ovf;
  } res_t;

  res_t         exp_q[$];
  logic [127:0] m_acc;
  int           m_cnt;
  bit           m_ovf;

  ved_mac_64 #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  ved_mac_64 #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_last(s_in_last), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_acc(s_out_acc), .out_cnt(s_out_cnt), .out_ovf(s_out_ovf)
  );

  always #5 clk = ~clk;

  // Frame model: exact wide products, wrap and carry detection by plain arithmetic
  task automatic model_clear();
    m_acc = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_beat(input logic [63:0] a, input logic [63:0] b, input bit last);
    logic [255:0] prod;
    logic [255:0] s;
    res_t r;
    prod = {192'b0, a} * {192'b0, b};
    s = {128'b0, m_acc} + prod;
    if (s[255:128] != 0) m_ovf = 1'b1;
    m_acc = s[127:0];
    m_cnt = m_cnt + 1;
    if (last) begin
      r.acc = m_acc;
      r.cnt = (m_cnt > 65535) ? 65535 : m_cnt;
      r.ovf = m_ovf;
      exp_q.push_back(r);
      model_clear();
    end
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input bit last);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    tests_run++;
    if ({out_valid, out_acc, out_cnt, out_ovf, in_ready} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got valid=%0b acc=%0h cnt=%0d ovf=%0b ready=%0b, want all 0",
               out_valid, out_acc, out_cnt, out_ovf, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_ready: got %0b, want 1", in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    applyStimulus(64'd5, 64'd6, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_early: out_valid got %0b, want 0 one edge after accept", out_valid);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_acc !== 128'd30 || out_cnt !== 16'd1 || out_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_result: got valid=%0b acc=%0d cnt=%0d ovf=%0b, want 1/30/1/0",
               out_valid, out_acc, out_cnt, out_ovf);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_clear: out_valid got %0b, want 0", out_valid);
    end
  endtask

  task automatic test_frame3();
    bit ok;
    bit ready_ok = 1'b1;
    logic [63:0] bs [3] = '{64'd250, 64'd254, 64'd255};
    out_ready = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(64'd255, bs[i], i == 2);
      model_beat(64'd255, bs[i], i == 2);
      #1;
      if (in_ready !== 1'b1) ready_ok = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (!ready_ok) begin
      fails++;
      $display("[TB] FAIL frame3_ready: in_ready dropped during frame, want 1 throughout");
    end
    wait_out(ok);
    tests_run++;
    if (!ok || out_acc !== 128'd193545 || out_acc !== exp_q[0].acc || out_cnt !== 16'd3 || out_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL frame3_result: got ok=%0b acc=%0d cnt=%0d ovf=%0b, want acc=193545 cnt=3 ovf=0",
               ok, out_acc, out_cnt, out_ovf);
    end
    exp_q.delete();
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL frame3_once: out_valid got %0b after result taken, want 0", out_valid);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    out_ready = 1'b1;
    applyStimulus('1, '1, 1'b0);
    applyStimulus('1, '1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(ok);
    tests_run++;
    if (!ok || out_acc !== 128'hFFFFFFFFFFFFFFFC0000000000000002 || out_cnt !== 16'd2 || out_ovf !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrap_result: got ok=%0b acc=%0h cnt=%0d ovf=%0b, want acc=fffffffffffffffc0000000000000002 cnt=2 ovf=1",
               ok, out_acc, out_cnt, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    applyStimulus(64'd6, 64'd7, 1'b1);
    applyStimulus(64'd9, 64'd7, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_acc !== 128'd42 || in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stall_hold: got valid=%0b acc=%0d ready=%0b, want 1/42/0", out_valid, out_acc, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_acc !== 128'd42 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stall_release: got acc=%0d ready=%0b, want 42/1", out_acc, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_acc !== 128'd63 || out_cnt !== 16'd1 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL back_to_back: got valid=%0b acc=%0d cnt=%0d ready=%0b, want 1/63/1/1",
               out_valid, out_acc, out_cnt, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL back_to_back_drain: out_valid got %0b, want 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    out_ready = 1'b1;
    applyStimulus(64'd15, 64'd15, 1'b0);
    applyStimulus(64'd30, 64'd30, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_acc, out_cnt, out_ovf, in_ready} !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: got valid=%0b acc=%0h cnt=%0d ovf=%0b ready=%0b, want all 0",
               out_valid, out_acc, out_cnt, out_ovf, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(64'd25, 64'd25, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(ok);
    tests_run++;
    if (!ok || out_acc !== 128'd625 || out_cnt !== 16'd1 || out_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_result: got ok=%0b acc=%0d cnt=%0d ovf=%0b, want 625/1/0",
               ok, out_acc, out_cnt, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    bit ok = 1'b0;
    bit ready_ok = 1'b1;
    s_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_a = 64'd1;
      s_in_b = 64'd1;
      s_in_last = (i == 4);
      #1;
      if (s_in_ready !== 1'b1) ready_ok = 1'b0;
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = s_out_valid;
    end
    tests_run++;
    if (!ok || !ready_ok || s_out_cnt !== 2'd3 || s_out_acc !== 128'd5 || s_out_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL saturate: got ok=%0b ready_ok=%0b cnt=%0d acc=%0d ovf=%0b, want cnt=3 acc=5 ovf=0",
               ok, ready_ok, s_out_cnt, s_out_acc, s_out_ovf);
    end
  endtask

  task automatic test_random();
    bit pend = 1'b0;
    bit closing = 1'b0;
    int idle = 0;
    logic [63:0] a, b;
    bit last;
    res_t r;
    model_clear();
    exp_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (cyc >= 600) closing = 1'b1;
      if (!pend && !closing && ($urandom % 10) < 7) begin
        case ($urandom % 4)
          0: begin a = '1; b = '1; end
          1: begin a = 64'($urandom % 1000); b = 64'($urandom % 1000); end
          default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        endcase
        last = ($urandom % 3) == 0;
        pend = 1'b1;
      end else if (!pend && closing && m_cnt > 0) begin
        a = 64'($urandom); b = 64'($urandom); last = 1'b1;
        pend = 1'b1;
      end
      in_valid = pend;
      in_a = a;
      in_b = b;
      in_last = last;
      out_ready = closing ? 1'b1 : (($urandom % 10) < 6);
      #1;
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL random_spurious: got acc=%0h cnt=%0d, want no result", out_acc, out_cnt);
        end else begin
          r = exp_q.pop_front();
          if (out_acc !== r.acc || out_cnt !== 16'(r.cnt) || out_ovf !== r.ovf) begin
            fails++;
            $display("[TB] FAIL random_result: got acc=%0h cnt=%0d ovf=%0b, want acc=%0h cnt=%0d ovf=%0b",
                     out_acc, out_cnt, out_ovf, r.acc, r.cnt, r.ovf);
          end
        end
      end
      if (in_valid && in_ready) begin
        model_beat(a, b, last);
        pend = 1'b0;
      end
      if (closing && !pend && m_cnt == 0 && exp_q.size() == 0 && !out_valid) begin
        idle++;
        if (idle > 4) break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (exp_q.size() != 0 || pend) begin
      fails++;
      $display("[TB] FAIL random_drain: got %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin
    $display("[TB] ved_mac_64 bench starting");
    test_reset();
    test_single();
    test_frame3();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
